rotate_sequencer: RTL and testbench

//  Sequential driver for the 4-bit combinational rotator barrel_shift (out, in, direction).

---
 rtl/rotate_sequencer_pkg.sv | 28 ++
 rtl/rotate_sequencer_if.sv | 33 +++
 rtl/rotate_sequencer_barrel_shift.sv | 25 ++
 rtl/rotate_sequencer.sv | 102 ++++++++++
 tb/tb_rotate_sequencer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/rotate_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rotate_pkg
// Brief    : Shared constants and types for the rotate_sequencer slice
//            (FSM encoding, rotate direction, divider defaults).
// Revision : 1.0 - initial release
// ============================================================================
package rotate_pkg;

  // Two-state sequencer encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Rotate direction encoding on the dir control
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Divider terminal values: one step per second on a 50 MHz board, fast for sim
  localparam int unsigned DIV_WIDTH_DEFAULT   = 27;
  localparam int unsigned DIV_TERMINAL_BOARD  = 49_999_999;
  localparam int unsigned DIV_TERMINAL_SIM    = 3;

  typedef logic [3:0] pattern_t;

  localparam pattern_t PAT_RESET_DEFAULT = 4'b0001;

endpackage : rotate_pkg
`default_nettype wire

// File: rtl/rotate_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : rotate_sequencer_if
// Brief    : Board-control and display-side bundle of the rotate sequencer.
//            master = control/consumer side, slave = sequencer side.
// Revision : 1.0 - initial release
// ============================================================================
interface rotate_sequencer_if;
  import rotate_pkg::*;

  logic       load;
  pattern_t   load_val;
  logic       start;
  logic       stop;
  logic       step;
  logic       dir;
  pattern_t   pattern;
  logic       tick;
  logic       running;
  logic [7:0] step_cnt;

  modport master (
    output load, load_val, start, stop, step, dir,
    input  pattern, tick, running, step_cnt
  );

  modport slave (
    input  load, load_val, start, stop, step, dir,
    output pattern, tick, running, step_cnt
  );

endinterface : rotate_sequencer_if
`default_nettype wire

// File: rtl/rotate_sequencer_barrel_shift.sv
`default_nettype none
// ============================================================================
// Module   : barrel_shift
// Brief    : 4-bit combinational rotate by one position, left or right.
// Revision : 1.0 - initial release
// ============================================================================
module barrel_shift
  import rotate_pkg::*;
(
  output pattern_t out,
  input  pattern_t in,
  input  logic     direction
);

  // Left moves bit 3 into bit 0; right moves bit 0 into bit 3
  always_comb begin
    if (direction == DIR_LEFT) begin
      out = {in[2:0], in[3]};
    end else begin
      out = {in[0], in[3:1]};
    end
  end

endmodule : barrel_shift
`default_nettype wire

// File: rtl/rotate_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rotate_sequencer
// Brief    : Holds a 4-bit pattern and rotates it either on a single-step
//            request (IDLE) or once per divided-clock period (RUN).
// Revision : 1.0 - initial release
// ============================================================================
module rotate_sequencer
  import rotate_pkg::*;
#(
  parameter int unsigned DIV_WIDTH    = DIV_WIDTH_DEFAULT,
  parameter int unsigned DIV_TERMINAL = DIV_TERMINAL_BOARD,
  parameter pattern_t    PAT_RESET    = PAT_RESET_DEFAULT
)(
  input  logic             clk,
  input  logic             rst,
  rotate_sequencer_if.slave bus
);

  localparam logic [DIV_WIDTH-1:0] C_DIV_TERM = DIV_WIDTH'(DIV_TERMINAL);

  logic [0:0]           state_q,   state_d;
  pattern_t             pattern_q, pattern_d;
  logic [DIV_WIDTH-1:0] div_q,     div_d;
  logic [7:0]           cnt_q,     cnt_d;
  logic                 tick_q;
  logic                 running_q;
  logic                 commit;
  pattern_t             rot;

  barrel_shift u_rot (
    .out       (rot),
    .in        (pattern_q),
    .direction (bus.dir)
  );

  // Next-state: mode transitions, pattern source selection, step-period divider
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    commit    = 1'b0;

    if (state_q == ST_RUN) begin
      if (bus.stop) begin
        state_d = ST_IDLE;
        div_d   = '0;
      end else if (bus.load) begin
        pattern_d = bus.load_val;
        div_d     = '0;
      end else if (div_q == C_DIV_TERM) begin
        commit = 1'b1;
        div_d  = '0;
      end else begin
        div_d = div_q + DIV_WIDTH'(1);
      end
    end else begin
      div_d = '0;
      if (bus.load) begin
        pattern_d = bus.load_val;
      end else if (bus.step) begin
        commit = 1'b1;
      end
      // A load still lets start through; a step takes precedence over start
      if (bus.start && !bus.stop && (bus.load || !bus.step)) begin
        state_d = ST_RUN;
      end
    end

    if (commit) begin
      pattern_d = rot;
      cnt_d     = cnt_q + 8'd1;
    end
  end

  // State and output registers; reset wins over every control input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pattern_q <= PAT_RESET;
      div_q     <= '0;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      tick_q    <= commit;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign bus.pattern  = pattern_q;
  assign bus.tick     = tick_q;
  assign bus.running  = running_q;
  assign bus.step_cnt = cnt_q;

endmodule : rotate_sequencer
`default_nettype wire

// File: tb/tb_rotate_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rotate_sequencer
// Brief    : Self-checking bench for rotate_sequencer with DIV_TERMINAL=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rotate_sequencer;

  typedef struct {
    logic [3:0] pattern;
    logic       tick;
    logic       running;
    logic [7:0] step_cnt;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       stop;
    logic       step;
    logic       dir;
    exp_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int tests  = 0;
  int failed = 0;

  vec_t tbl[$];
  exp_t exp_q[$];

  rotate_sequencer_if bus ();

  rotate_sequencer #(
    .DIV_WIDTH    (27),
    .DIV_TERMINAL (3),
    .PAT_RESET    (4'b0001)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic r, input logic ld, input logic [3:0] lv,
                     input logic st, input logic sp, input logic stp, input logic d,
                     input logic [3:0] p, input logic t, input logic rn, input logic [7:0] c);
    vec_t v;
    v.rst = r; v.load = ld; v.load_val = lv; v.start = st; v.stop = sp;
    v.step = stp; v.dir = d;
    v.exp.pattern = p; v.exp.tick = t; v.exp.running = rn; v.exp.step_cnt = c;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    rst          = v.rst;
    bus.load     = v.load;
    bus.load_val = v.load_val;
    bus.start    = v.start;
    bus.stop     = v.stop;
    bus.step     = v.step;
    bus.dir      = v.dir;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      tests++; failed++;
      $display("FAIL scoreboard vec %0d: got empty queue expected entry", idx);
    end else begin
      e = exp_q.pop_front();
      chk("pattern",  idx, int'(bus.pattern),  int'(e.pattern));
      chk("tick",     idx, int'(bus.tick),     int'(e.tick));
      chk("running",  idx, int'(bus.running),  int'(e.running));
      chk("step_cnt", idx, int'(bus.step_cnt), int'(e.step_cnt));
    end
  endtask

  initial begin
    logic [3:0] p;
    vec_t v;
    bus.load = 0; bus.load_val = 0; bus.start = 0; bus.stop = 0; bus.step = 0; bus.dir = 0;

    // reset
    add(1,0,4'h0,0,0,0,0, 4'h1,0,0,8'd0);
    // free run left: rotation every 4 cycles
    add(0,0,4'h0,1,0,0,1, 4'h1,0,1,8'd0);
    p = 4'h1;
    for (int k = 1; k <= 4; k++) begin
      for (int j = 0; j < 3; j++) add(0,0,4'h0,0,0,0,1, p,0,1,8'(k-1));
      p = {p[2:0], p[3]};
      add(0,0,4'h0,0,0,0,1, p,1,1,8'(k));
    end
    add(0,0,4'h0,0,1,0,1, 4'h1,0,0,8'd4);
    // load then single step right in IDLE
    add(0,1,4'hB,0,0,0,0, 4'hB,0,0,8'd4);
    add(0,0,4'h0,0,0,1,0, 4'hD,1,0,8'd5);
    add(0,0,4'h0,0,0,0,0, 4'hD,0,0,8'd5);
    // stop on the terminal cycle: no rotation
    add(0,0,4'h0,1,0,0,1, 4'hD,0,1,8'd5);
    for (int j = 0; j < 3; j++) add(0,0,4'h0,0,0,0,1, 4'hD,0,1,8'd5);
    add(0,0,4'h0,0,1,0,1, 4'hD,0,0,8'd5);
    add(0,0,4'h0,0,0,0,1, 4'hD,0,0,8'd5);
    // load at div_cnt=2 restarts the period
    add(0,0,4'h0,1,0,0,1, 4'hD,0,1,8'd5);
    add(0,0,4'h0,0,0,0,1, 4'hD,0,1,8'd5);
    add(0,0,4'h0,0,0,0,1, 4'hD,0,1,8'd5);
    add(0,1,4'h6,0,0,0,1, 4'h6,0,1,8'd5);
    for (int j = 0; j < 3; j++) add(0,0,4'h0,0,0,0,1, 4'h6,0,1,8'd5);
    add(0,0,4'h0,0,0,0,1, 4'hC,1,1,8'd6);
    // reset mid-RUN at div_cnt=2, reset together with start
    add(0,0,4'h0,0,0,0,1, 4'hC,0,1,8'd6);
    add(0,0,4'h0,0,0,0,1, 4'hC,0,1,8'd6);
    add(1,0,4'h0,0,0,0,1, 4'h1,0,0,8'd0);
    add(1,0,4'h0,1,0,0,1, 4'h1,0,0,8'd0);
    add(0,0,4'h0,0,0,0,1, 4'h1,0,0,8'd0);
    // all-zeros and all-ones rotate to themselves
    add(0,1,4'h0,0,0,0,0, 4'h0,0,0,8'd0);
    add(0,0,4'h0,0,0,1,1, 4'h0,1,0,8'd1);
    add(0,1,4'hF,0,0,0,0, 4'hF,0,0,8'd1);
    add(0,0,4'h0,0,0,1,0, 4'hF,1,0,8'd2);
    // start+stop together stays IDLE
    add(0,0,4'h0,1,1,0,0, 4'hF,0,0,8'd2);
    add(0,0,4'h0,0,0,0,0, 4'hF,0,0,8'd2);
    // load+start: load then RUN; step/start ignored in RUN
    add(0,1,4'h9,1,0,0,1, 4'h9,0,1,8'd2);
    add(0,0,4'h0,1,0,1,1, 4'h9,0,1,8'd2);
    add(0,0,4'h0,0,0,1,1, 4'h9,0,1,8'd2);
    add(0,0,4'h0,0,0,0,1, 4'h9,0,1,8'd2);
    add(0,0,4'h0,0,0,0,1, 4'h3,1,1,8'd3);
    add(0,0,4'h0,0,1,0,1, 4'h3,0,0,8'd3);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // 256 single steps with random direction: step_cnt wraps back to 0
    v.rst = 1; v.load = 0; v.load_val = 0; v.start = 0; v.stop = 0; v.step = 0; v.dir = 0;
    v.exp.pattern = 4'h1; v.exp.tick = 0; v.exp.running = 0; v.exp.step_cnt = 0;
    apply(v, 1000);
    p = 4'h1;
    for (int i = 0; i < 256; i++) begin
      v.rst = 0; v.step = 1; v.dir = 1'($urandom_range(0, 1));
      p = v.dir ? {p[2:0], p[3]} : {p[0], p[3:1]};
      v.exp.pattern = p; v.exp.tick = 1; v.exp.running = 0;
      v.exp.step_cnt = 8'(i + 1);
      apply(v, 2000 + i);
    end
    v.step = 0;
    v.exp.tick = 0; v.exp.step_cnt = 8'd0;
    apply(v, 3000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_rotate_sequencer
`default_nettype wire
